// File: rtl/uart_calc_host.sv
// rtl/uart_calc_host.sv - on-chip host for the UART calculator protocol
// Sends {cmd, A, B} on oTx, collects the NBYTES+1 result bytes from iRx and decodes oRes.

module uart_tx #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTxStart,
  input  logic [7:0] iTxByte,
  output logic       oTxSerial,
  output logic       oTxBusy,
  output logic       oTxDone
);
  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int CLK_W = $clog2(CPB + 1);

  logic [CLK_W-1:0] clkCnt;
  logic [3:0]       bitIdx;
  logic [8:0]       shiftReg;

  // oTxDone marks the last clock of the stop bit so the next frame can start right after it
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oTxSerial <= 1'b1;
      oTxBusy   <= 1'b0;
      oTxDone   <= 1'b0;
      clkCnt    <= '0;
      bitIdx    <= '0;
      shiftReg  <= '1;
    end else begin
      oTxDone <= 1'b0;
      if (!oTxBusy) begin
        if (iTxStart) begin
          oTxBusy   <= 1'b1;
          oTxSerial <= 1'b0;
          shiftReg  <= {1'b1, iTxByte};
          clkCnt    <= '0;
          bitIdx    <= '0;
        end
      end else begin
        if (bitIdx == 4'd9 && clkCnt == CLK_W'(CPB - 2)) oTxDone <= 1'b1;
        if (clkCnt == CLK_W'(CPB - 1)) begin
          clkCnt <= '0;
          if (bitIdx == 4'd9) begin
            oTxBusy   <= 1'b0;
            oTxSerial <= 1'b1;
          end else begin
            bitIdx    <= bitIdx + 4'd1;
            oTxSerial <= shiftReg[0];
            shiftReg  <= {1'b1, shiftReg[8:1]};
          end
        end else begin
          clkCnt <= clkCnt + 1'b1;
        end
      end
    end
  end
endmodule

module uart_rx #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRxSerial,
  output logic [7:0] oRxByte,
  output logic       oRxDone
);
  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int CLK_W = $clog2(CPB + 1);

  logic [1:0]       rxSync;
  logic             active;
  logic [3:0]       bitIdx;
  logic [CLK_W-1:0] clkCnt;
  logic [CLK_W-1:0] sampleAt;
  logic [7:0]       data;

  assign sampleAt = (bitIdx == 4'd0) ? CLK_W'(CPB / 2 - 1) : CLK_W'(CPB - 1);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rxSync  <= 2'b11;
      active  <= 1'b0;
      bitIdx  <= '0;
      clkCnt  <= '0;
      data    <= '0;
      oRxByte <= '0;
      oRxDone <= 1'b0;
    end else begin
      rxSync  <= {rxSync[0], iRxSerial};
      oRxDone <= 1'b0;
      if (!active) begin
        if (!rxSync[1]) begin
          active <= 1'b1;
          bitIdx <= '0;
          clkCnt <= '0;
        end
      end else if (clkCnt != sampleAt) begin
        clkCnt <= clkCnt + 1'b1;
      end else begin
        clkCnt <= '0;
        if (bitIdx == 4'd0) begin
          if (rxSync[1]) active <= 1'b0;
          else           bitIdx <= 4'd1;
        end else if (bitIdx == 4'd9) begin
          active <= 1'b0;
          if (rxSync[1]) begin
            oRxByte <= data;
            oRxDone <= 1'b1;
          end
        end else begin
          data   <= {rxSync[1], data[7:1]};
          bitIdx <= bitIdx + 4'd1;
        end
      end
    end
  end
endmodule

module uart_calc_host #(
  parameter int CLK_FREQ       = 125_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int OPERAND_WIDTH  = 512,
  parameter int NBYTES         = OPERAND_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic [7:0]               iCmd,
  input  logic [OPERAND_WIDTH-1:0] iOpA,
  input  logic [OPERAND_WIDTH-1:0] iOpB,
  output logic                     oTx,
  input  logic                     iRx,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oTimeout,
  output logic [OPERAND_WIDTH:0]   oRes
);
  localparam int TX_BYTES = 2 * NBYTES + 1;
  localparam int RX_BYTES = NBYTES + 1;
  localparam int CNT_W    = $clog2(TX_BYTES + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CMD_COMPARE = 8'h43;

  typedef enum logic [2:0] {IDLE, TX_BYTE, WAIT_TX, RX_RES, DECODE} stateT;
  stateT state, stateNext;

  logic [TX_BYTES*8-1:0] txShift;
  logic [RX_BYTES*8-1:0] rxFrame;
  logic [7:0]            cmdLatched;
  logic [7:0]            txByte;
  logic [7:0]            rxByte;
  logic [CNT_W-1:0]      byteCnt;
  logic [TMO_W-1:0]      tmoCnt;
  logic                  uartRst;
  logic                  txStart, txBusy, txDone, rxDone;
  logic                  timeoutHit, doneNext, timeoutNext;

  assign uartRst    = ~iRst;
  assign oBusy      = (state != IDLE);
  assign txByte     = txShift[TX_BYTES*8-1 -: 8];
  // A byte arriving on the expiry cycle takes priority over the timeout
  assign timeoutHit = !rxDone && (tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    txStart     = 1'b0;
    doneNext    = 1'b0;
    timeoutNext = 1'b0;
    case (state)
      IDLE:    if (iStart) stateNext = TX_BYTE;
      TX_BYTE: if (!txBusy) begin
                 txStart   = 1'b1;
                 stateNext = WAIT_TX;
               end
      WAIT_TX: if (txDone) stateNext = (byteCnt < CNT_W'(TX_BYTES)) ? TX_BYTE : RX_RES;
      RX_RES:  if (rxDone && byteCnt == CNT_W'(RX_BYTES - 1)) begin
                 stateNext = DECODE;
               end else if (timeoutHit) begin
                 timeoutNext = 1'b1;
                 stateNext   = IDLE;
               end
      DECODE:  begin
                 doneNext  = 1'b1;
                 stateNext = IDLE;
               end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      txShift    <= '0;
      rxFrame    <= '0;
      cmdLatched <= '0;
      byteCnt    <= '0;
      tmoCnt     <= '0;
      oRes       <= '0;
      oDone      <= 1'b0;
      oTimeout   <= 1'b0;
    end else begin
      oDone    <= doneNext;
      oTimeout <= timeoutNext;
      if (state == IDLE && iStart) begin
        txShift    <= {iCmd, iOpA, iOpB};
        cmdLatched <= iCmd;
        oRes       <= '0;
        byteCnt    <= '0;
        tmoCnt     <= '0;
      end
      if (txStart) begin
        txShift <= txShift << 8;
        byteCnt <= byteCnt + 1'b1;
      end
      if (state == WAIT_TX && stateNext == RX_RES) begin
        byteCnt <= '0;
        tmoCnt  <= '0;
      end
      if (state == RX_RES) begin
        if (rxDone) begin
          rxFrame <= {rxFrame[RX_BYTES*8-9:0], rxByte};
          byteCnt <= byteCnt + 1'b1;
          tmoCnt  <= '0;
        end else begin
          tmoCnt <= tmoCnt + 1'b1;
        end
      end
      // Compare responses are left-justified with 7 pad bits below the result
      if (state == DECODE) begin
        oRes <= (cmdLatched == CMD_COMPARE) ? rxFrame[RX_BYTES*8-1:7] : rxFrame[OPERAND_WIDTH:0];
      end
    end
  end

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) uTx (
    .iClk      (iClk),
    .iRst      (uartRst),
    .iTxStart  (txStart),
    .iTxByte   (txByte),
    .oTxSerial (oTx),
    .oTxBusy   (txBusy),
    .oTxDone   (txDone)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) uRx (
    .iClk      (iClk),
    .iRst      (uartRst),
    .iRxSerial (iRx),
    .oRxByte   (rxByte),
    .oRxDone   (rxDone)
  );
endmodule

// File: tb/tb_uart_calc_host.sv
// tb/tb_uart_calc_host.sv - randomized bench with a behavioural calculator responder
`timescale 1ns/1ps
module tb_uart_calc_host;
  localparam int W   = 512;
  localparam int NB  = W / 8;
  localparam int CPB = 4;
  localparam int TMO = 1000;
  localparam int NTX = 2 * NB + 1;
  localparam int NRX = NB + 1;
  localparam int RW  = W + 1;
  localparam int RB  = NRX * 8;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic [7:0]    cmd;
  logic [W-1:0]  opA, opB;
  logic          tx, rx;
  logic          busy, done, timeout;
  logic [W:0]    res;

  int nChecks = 0, nErrors = 0;
  int cyc = 0;
  int nDone = 0, nTmo = 0, tmoCyc = 0;
  logic [7:0] txq[$];
  int txStarts[$];
  int mActive = 0, mStart = 0, mOff = 0, frameErrs = 0;
  logic [7:0] mData = 8'h00;

  uart_calc_host #(
    .CLK_FREQ(400), .BAUD_RATE(100), .OPERAND_WIDTH(W), .NBYTES(NB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .iClk(clk), .iRst(rstN), .iStart(start), .iCmd(cmd), .iOpA(opA), .iOpB(opB),
    .oTx(tx), .iRx(rx), .oBusy(busy), .oDone(done), .oTimeout(timeout), .oRes(res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line-level receiver for oTx: mid-bit sampling, LSB first
  always @(negedge clk) begin
    if (!rstN) begin
      mActive = 0;
    end else if (mActive == 0) begin
      if (tx == 1'b0) begin
        mActive = 1;
        mStart  = cyc;
        txStarts.push_back(cyc);
      end
    end else begin
      mOff = cyc - mStart;
      if (mOff == CPB / 2) begin
        if (tx != 1'b0) frameErrs++;
      end else if (mOff < 9 * CPB && (mOff % CPB) == CPB / 2) begin
        mData = {tx, mData[7:1]};
      end else if (mOff == 9 * CPB + CPB / 2) begin
        if (tx != 1'b1) frameErrs++;
        txq.push_back(mData);
        mActive = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) nDone++;
    if (timeout) begin
      nTmo++;
      tmoCyc = cyc;
    end
  end

  task automatic sendByte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = frame[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  function automatic logic [W-1:0] randOp();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [RB-1:0] randResp();
    logic [RB-1:0] v;
    for (int i = 0; i < NRX; i++) v[i*8 +: 8] = 8'($urandom());
    return v;
  endfunction

  task automatic runTxn(input logic [7:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RB-1:0] resp, input bit silent, input bit extra, input string tag);
    logic [7:0]    expTx[$];
    logic [RB-1:0] shifted;
    logic [W:0]    expRes;
    int d0, t0, acc, n, mism, lastEnd;
    bit pulsed;
    expTx.delete();
    expTx.push_back(c);
    for (int i = NB - 1; i >= 0; i--) expTx.push_back(8'(a >> (8 * i)));
    for (int i = NB - 1; i >= 0; i--) expTx.push_back(8'(b >> (8 * i)));
    shifted = resp >> 7;
    expRes  = silent ? '0 : (c == 8'h43) ? shifted[W:0] : resp[W:0];

    txq.delete();
    txStarts.delete();
    frameErrs = 0;
    d0 = nDone;
    t0 = nTmo;
    @(negedge clk);
    start = 1'b1; cmd = c; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; cmd = ~c; opA = ~a; opB = ~b;
    acc = cyc;
    checkEq({tag, " busy after start"}, RW'(busy), RW'(1));
    checkEq({tag, " res cleared"}, res, '0);

    n = 0;
    pulsed = 0;
    while (txq.size() < NTX && n < NTX * (10 * CPB + 2) + 50) begin
      @(negedge clk);
      n++;
      if (extra && !pulsed && txq.size() == 10) begin
        start = 1'b1; cmd = 8'h5A; opA = randOp(); opB = randOp();
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkEq({tag, " tx frames"}, RW'(txq.size()), RW'(NTX));
    mism = 0;
    for (int i = 0; i < NTX; i++) if (i >= txq.size() || txq[i] !== expTx[i]) mism++;
    checkEq({tag, " tx bytes wrong"}, RW'(mism), '0);
    checkEq({tag, " tx framing errors"}, RW'(frameErrs), '0);
    lastEnd = (txStarts.size() > 0) ? txStarts[txStarts.size() - 1] + 10 * CPB : acc;
    checkEq({tag, " tx latency within bound"}, RW'((lastEnd - acc) <= NTX * (10 * CPB + 2)), RW'(1));

    if (silent) begin
      n = 0;
      while (nTmo == t0 && n < TMO + 20 * CPB + 100) begin
        @(negedge clk);
        n++;
      end
      checkEq({tag, " timeout pulses"}, RW'(nTmo - t0), RW'(1));
      checkEq({tag, " timeout delay after idle line"}, RW'(tmoCyc - lastEnd), RW'(TMO));
      checkEq({tag, " busy after timeout"}, RW'(busy), '0);
    end else begin
      repeat (2 * CPB) @(negedge clk);
      for (int i = 0; i < NRX; i++) begin
        if (extra && i == 4) begin
          @(negedge clk);
          start = 1'b1; cmd = 8'h43; opA = randOp();
          @(negedge clk);
          start = 1'b0;
        end
        sendByte(resp[(NRX - 1 - i) * 8 +: 8]);
      end
      n = 0;
      while (nDone == d0 && n < 20 * CPB + 100) begin
        @(negedge clk);
        n++;
      end
      checkEq({tag, " busy with done"}, RW'(busy), '0);
    end
    repeat (4) @(negedge clk);
    checkEq({tag, " result"}, res, expRes);
    checkEq({tag, " done pulses"}, RW'(nDone - d0), RW'(silent ? 0 : 1));
    if (!silent) checkEq({tag, " timeout pulses"}, RW'(nTmo - t0), '0);
  endtask

  initial begin
    int d0, t0, n;
    rstN = 1'b0; start = 1'b0; cmd = '0; opA = '0; opB = '0; rx = 1'b1;
    repeat (3) @(negedge clk);
    checkEq("reset tx", RW'(tx), RW'(1));
    checkEq("reset busy", RW'(busy), '0);
    checkEq("reset done", RW'(done), '0);
    checkEq("reset timeout", RW'(timeout), '0);
    checkEq("reset res", res, '0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    runTxn(8'h41, W'(1), W'(2), RB'(3), 0, 0, "add");
    runTxn(8'h43, randOp(), randOp(), RB'(8'h80), 0, 0, "compare");
    runTxn(8'h41, {W{1'b1}}, W'(1), {8'h01, {NB{8'h00}}}, 0, 0, "carry");
    runTxn(8'h41, randOp(), randOp(), '0, 1, 0, "silent");
    runTxn(8'h41, W'(1), W'(2), RB'(3), 0, 1, "extra start");

    d0 = nDone; t0 = nTmo;
    txStarts.delete();
    @(negedge clk);
    start = 1'b1; cmd = 8'h41; opA = W'(1); opB = W'(2);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (txStarts.size() < 40 && n < 40 * (10 * CPB + 2) + 50) begin
      @(negedge clk);
      n++;
    end
    checkEq("reset reached frame 40", RW'(txStarts.size()), RW'(40));
    repeat (3 * CPB) @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    checkEq("async reset tx", RW'(tx), RW'(1));
    checkEq("async reset busy", RW'(busy), '0);
    @(negedge clk);
    @(negedge clk) rstN = 1'b1;
    repeat (TMO + 100) @(negedge clk);
    checkEq("post reset done", RW'(nDone - d0), '0);
    checkEq("post reset timeout", RW'(nTmo - t0), '0);
    checkEq("post reset res", res, '0);
    runTxn(8'h41, W'(1), W'(2), RB'(3), 0, 0, "after reset");

    for (int r = 0; r < 2; r++) begin
      logic [7:0] c;
      case ($urandom_range(0, 2))
        0:       c = 8'h41;
        1:       c = 8'h43;
        default: c = 8'h4D;
      endcase
      runTxn(c, randOp(), randOp(), randResp(), 0, 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #(120_000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget, checks %0d errors %0d", nChecks, nErrors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_calc_host.md
Name: uart_calc_host

Overview:
- Host-side initiator for the UART calculator protocol: performs the laptop's role on-chip.
- On iStart, serialises a command byte and operands A and B over oTx. Then collects the NBYTES+1 result bytes on iRx and presents the decoded (OPERAND_WIDTH+1)-bit result.
- Used for board-level self-test (oTx/iRx cross-wired to the calculator UART) and as a bench driver.
- Instantiates the existing uart_tx and uart_rx modules.

Parameters:
- CLK_FREQ, 125_000_000, system clock in Hz (passed to uart_tx/uart_rx)
- BAUD_RATE, 115_200, UART bit rate
- OPERAND_WIDTH, 512, operand width in bits (multiple of 8)
- NBYTES, OPERAND_WIDTH/8, bytes per operand
- TIMEOUT_CYCLES, 50_000_000, maximum idle clocks between response bytes (including before the first)

Ports:
- iClk  in  1  system clock
- iRst  in  1  asynchronous, active-low reset
- iStart  in  1  one-cycle request; sampled only in IDLE
- iCmd  in  8  command byte (ASCII; "C" = 0x43 selects the compare response format)
- iOpA  in  OPERAND_WIDTH  operand A
- iOpB  in  OPERAND_WIDTH  operand B
- oTx  out  1  serial line to calculator, idle high
- iRx  in  1  serial line from calculator
- oBusy  out  1  high from the cycle after an accepted iStart until oDone/oTimeout
- oDone  out  1  one-cycle pulse; oRes valid from this cycle onward
- oTimeout  out  1  one-cycle pulse on response timeout
- oRes  out  OPERAND_WIDTH+1  decoded result, held until the next accepted iStart

Behaviour:
- Reset (iRst=0, asynchronous): state IDLE, oBusy=0, oDone=0, oTimeout=0, oRes=0, counters cleared, oTx=1. uart_tx/uart_rx receive the inverted (active-high) reset.
- iStart in IDLE:
  - latch iCmd, iOpA, iOpB into a (2*NBYTES+1)-byte shift register {cmd, A, B};
  - clear oRes;
  - enter TX_BYTE the next cycle.
- iStart outside IDLE is ignored; no latch occurs.
- TX_BYTE: when uart_tx busy=0, pulse iTxStart for 1 cycle with the uppermost byte, shift left 8, increment the byte counter, go to WAIT_TX.
- WAIT_TX: wait for the uart_tx done pulse.
  - Counter < 2*NBYTES+1: return to TX_BYTE.
  - Otherwise clear counters and go to RX_RES.
- Byte order on the wire: command, then A MSB-first (A[OPERAND_WIDTH-1:OPERAND_WIDTH-8] first), then B MSB-first. Total 2*NBYTES+1 frames.
- Bytes received on iRx before RX_RES are discarded.
- RX_RES:
  - each uart_rx done pulse shifts the byte into the LSB end of an (NBYTES+1)*8-bit frame register and resets the timeout counter;
  - after NBYTES+1 bytes, go to DECODE;
  - if the timeout counter reaches TIMEOUT_CYCLES, pulse oTimeout, leave oRes=0, go to IDLE.
- Response byte order: first received byte is the most significant.
- DECODE (1 cycle), then pulse oDone and go to IDLE:
  - latched cmd == 0x43: oRes = frame[(NBYTES+1)*8-1:7] (result left-justified, 7 zero pad bits at the bottom);
  - otherwise: oRes = frame[OPERAND_WIDTH:0] (7 zero pad bits at the top).
- oBusy falls in the same cycle oDone or oTimeout is asserted.
- Latency from iStart to the last TX stop bit: (2*NBYTES+1) frames plus at most 2 clocks per byte of handshake overhead.
- Reset mid-operation: the transfer is abandoned immediately. No partial result or pulse appears after reset release.
- A uart_rx done pulse in the same cycle the timeout expires: the byte wins and the timeout counter clears.

Test Plan:
Bench is a behavioural calculator responder on iRx/oTx.
1. iCmd=0x41, A=1, B=2; responder returns 65 bytes 00…00 03 -> oTx carries 0x41, 63×0x00, 0x01, 63×0x00, 0x02 (129 frames); oDone pulses once; oRes=3; oBusy low after.
2. iCmd=0x43, any A/B; responder returns 64×0x00 then 0x80 -> oRes=1 (left-justified decode).
3. iCmd=0x41, A=2^512-1, B=1; responder returns 0x01 then 64×0x00 -> oRes=2^512 (bit 512 set, all others 0).
4. Responder silent after operands, TIMEOUT_CYCLES=1000 -> oTimeout pulses exactly 1000 clocks after the last TX done, oDone never pulses, oRes=0, state IDLE.
5. Second iStart pulses during TX and during RX_RES -> ignored; exactly 129 frames on oTx; one oDone.
6. Assert iRst low during the 40th TX frame -> oTx=1 and oBusy=0 asynchronously. After release, no oDone/oTimeout; a fresh iStart completes scenario 1 correctly.
